corr_input_conditioner: RTL
===========================

// Module: corr_input_conditioner
// PURPOSE
// Conditions the two raw probe signals (x, y) that feed the correlator.
// - Synchronises each probe into i_clk and optionally inverts it.
// - Debounces each probe with a programmable glitch filter.
// - Reduces each probe's activity between sample strobes to one bit (level/sticky/rise/toggle).
// - The bit is held on o_x/o_y for the correlation counters.
// Sits directly upstream of the correlator; i_strobe is the correlator's sample strobe.
// PARAMETERS
// SYNC_STAGES  2  synchroniser flops per probe, >=2
// FILTER_W     4  width of debounce length/counter; max filter length 2**FILTER_W-1
// PORTS
// i_clk         in   1         clock
// i_rst_n       in   1         reset, asynchronous, active-low
// i_cg          in   1         clock gate; 0 => every flop holds
// i_x, i_y      in   1         raw asynchronous probe inputs
// i_invertX/Y   in   1         1 => invert probe after synchroniser
// i_mode        in   2         0=LEVEL 1=STICKY 2=RISE 3=TOGGLE (both channels)
// i_filterLen   in   FILTER_W  debounce length N (0 = no filtering)
// i_strobe      in   1         sample strobe, single-cycle pulse
// o_x, o_y      out  1         conditioned sample, updated on strobe
// o_valid       out  1         1-cycle pulse: o_x/o_y updated this cycle
// BEHAVIOUR
// - Reset: all sync/filter/accumulator flops, o_x, o_y, o_valid = 0.
// - Per channel c (identical):
//   - Sync: s = last stage of SYNC_STAGES flop chain, XOR i_invertC.
//   - Debounce: registered f, counter cnt[FILTER_W].
//     - s==f: cnt<=0.
//     - else if cnt==i_filterLen: f<=s, cnt<=0.
//     - else cnt<=cnt+1.
//     - A pulse on s passes iff it is >= N+1 cycles wide.
//     - Latency from i_c to f is SYNC_STAGES+1+N cycles.
//   - Edge reference fp<=f every enabled cycle. Events: rise=f&~fp, tog=f^fp.
//   - Accumulators accS|=f, accR|=rise, accT|=tog every enabled cycle.
// - Strobe (i_cg && i_strobe):
//   - o_c <= mode LEVEL: f | STICKY: accS|f | RISE: accR|rise | TOGGLE: accT|tog.
//   - Current-cycle events count toward this sample; all acc<=0 (not carried over).
// - o_valid <= i_cg && i_strobe (registered). o_x/o_y hold between strobes.
// - All accumulators run in every mode, so a mode change takes effect at the next strobe.
// - i_filterLen lowered below cnt mid-count: cnt!=N, so cnt keeps incrementing.
//   It wraps at 2**FILTER_W and matches N later. This is allowed and no saturation is needed.
// - Strobe on consecutive cycles: each strobe samples one cycle of activity. No loss.
// - Async reset mid-window clears everything immediately.
//   First sample after reset reflects only post-reset activity.
// - i_invert change looks like a probe edge and is filtered like any other.
// TESTING
// 1. Defaults, N=0, LEVEL: i_x 0->1 held.
//    -> f rises 3 cycles later; next strobe gives o_x=1, o_valid pulse 1 cycle.
// 2. N=3, 3-cycle pulse on i_y -> f never changes, o_y stays 0.
//    Same with a 4-cycle pulse -> f high for 4 cycles.
// 3. STICKY, strobe period 16, one 2-cycle pulse (N=0) mid-window
//    -> o_x=1 for that sample only, 0 at the following strobe.
// 4. RISE vs LEVEL: i_x held high across 3 strobes
//    -> RISE gives 1,0,0; LEVEL gives 1,1,1. TOGGLE on a 1->0 fall gives 1.
// 5. Edge reaches f on the exact strobe cycle (RISE)
//    -> counted in that sample (o_x=1), not in the next (0).
// 6. Assert i_rst_n=0 mid-window with accS=1, release
//    -> o_x=o_y=o_valid=0 at once; next strobe with idle inputs gives o_x=0.
//    Also: i_cg=0 for 5 cycles with strobe pulses -> no o_valid, state frozen.

Source files
------------

// File: rtl/corr_input_conditioner.sv
// Input conditioner for the correlator: synchronises, optionally inverts, debounces and
// reduces each probe (x, y) to one bit per sample strobe.
module corr_input_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W    = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_cg,
  input  logic                i_x,
  input  logic                i_y,
  input  logic                i_invertX,
  input  logic                i_invertY,
  input  logic [1:0]          i_mode,
  input  logic [FILTER_W-1:0] i_filterLen,
  input  logic                i_strobe,
  output logic                o_x,
  output logic                o_y,
  output logic                o_valid
);

  localparam logic [1:0] MODE_LEVEL  = 2'd0;
  localparam logic [1:0] MODE_STICKY = 2'd1;
  localparam logic [1:0] MODE_RISE   = 2'd2;
  localparam logic [1:0] MODE_TOGGLE = 2'd3;

  // Channel index 0 is x, 1 is y throughout.
  logic [SYNC_STAGES-1:0] syncChain [2];
  logic [FILTER_W-1:0]    cnt [2];
  logic [1:0] probe, invert, s;
  logic [1:0] f, fp, rise, tog;
  logic [1:0] accS, accR, accT, sample;

  always_comb begin
    probe  = {i_y, i_x};
    invert = {i_invertY, i_invertX};
    s      = '0;
    for (int unsigned c = 0; c < 2; c++) begin
      s[c] = syncChain[c][SYNC_STAGES-1] ^ invert[c];
    end
    rise = f & ~fp;
    tog  = f ^ fp;
    // Current-cycle level/event is OR-ed in so activity on the strobe cycle lands in this sample.
    unique case (i_mode)
      MODE_LEVEL:  sample = f;
      MODE_STICKY: sample = accS | f;
      MODE_RISE:   sample = accR | rise;
      MODE_TOGGLE: sample = accT | tog;
      default:     sample = f;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned c = 0; c < 2; c++) begin
        syncChain[c] <= '0;
        cnt[c]       <= '0;
      end
      f       <= '0;
      fp      <= '0;
      accS    <= '0;
      accR    <= '0;
      accT    <= '0;
      o_x     <= 1'b0;
      o_y     <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= i_cg & i_strobe;
      if (i_cg) begin
        for (int unsigned c = 0; c < 2; c++) begin
          syncChain[c] <= {syncChain[c][SYNC_STAGES-2:0], probe[c]};
          // cnt may run past a lowered filter length; it wraps and matches later.
          if (s[c] == f[c]) begin
            cnt[c] <= '0;
          end else if (cnt[c] == i_filterLen) begin
            f[c]   <= s[c];
            cnt[c] <= '0;
          end else begin
            cnt[c] <= cnt[c] + 1'b1;
          end
        end
        fp <= f;
        if (i_strobe) begin
          o_x  <= sample[0];
          o_y  <= sample[1];
          accS <= '0;
          accR <= '0;
          accT <= '0;
        end else begin
          accS <= accS | f;
          accR <= accR | rise;
          accT <= accT | tog;
        end
      end
    end
  end

endmodule
